// File: rtl/adder_display_pkg.sv
// Shared definitions for the multi-digit adder display: page encodings,
// active-low hex segment patterns and the page rotation order.
package adder_display_pkg;

  typedef enum logic [1:0] {
    PAGE_A    = 2'd0,
    PAGE_B    = 2'd1,
    PAGE_SUM  = 2'd2,
    PAGE_AUTO = 2'd3
  } page_e;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Index n holds the glyph for hex digit n; bit 0 = segment a, bit 6 = segment g.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  function automatic page_e next_page(input page_e p);
    case (p)
      PAGE_A:  return PAGE_B;
      PAGE_B:  return PAGE_SUM;
      default: return PAGE_A;
    endcase
  endfunction

endpackage

// File: rtl/hex_to_svn_seg.sv
// Combinational 4-bit nibble to active-low seven-segment glyph decoder.
module hex_to_svn_seg
  import adder_display_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = SEG_TABLE[nibble];

endmodule

// File: rtl/multi_digit_adder_display.sv
// Registered ripple-carry adder whose operands or sum are shown on a
// time-multiplexed active-low seven-segment display with optional auto-rotate.
module multi_digit_adder_display
  import adder_display_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int DIGITS       = 4,
  parameter int REFRESH_DIV  = 100000,
  parameter int ROTATE_SCANS = 256,
  parameter int BLANK_ZEROS  = 1
) (
  input  logic              clk,
  input  logic              clr,
  input  logic [WIDTH-1:0]  a,
  input  logic [WIDTH-1:0]  b,
  input  logic              c_in,
  input  logic              load,
  input  logic [1:0]        mode,
  output logic              valid,
  output logic [DIGITS-1:0] an,
  output logic [6:0]        ca,
  output logic              dp
);

  localparam int RCW  = $clog2(REFRESH_DIV);
  localparam int DW   = $clog2(DIGITS);
  localparam int ROTW = $clog2(ROTATE_SCANS + 1);
  localparam int PW   = 4 * DIGITS + 20;

  logic [WIDTH-1:0]  ra_reg, rb_reg;
  logic              rc_reg;
  logic [WIDTH:0]    rs_reg;
  logic              valid_reg, pend_reg;
  logic [RCW-1:0]    refresh_reg;
  logic [DW-1:0]     digit_idx_reg, disp_idx_reg;
  logic              live_reg;
  logic [ROTW-1:0]   rotate_reg;
  page_e             page_reg;
  logic              auto_reg;
  logic [DIGITS-1:0] an_reg;
  logic [6:0]        ca_reg;
  logic              dp_reg;

  // Explicit ripple-carry chain over the captured operands.
  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum_bits;
  assign carry[0] = rc_reg;
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_ripple
    assign sum_bits[gi]  = ra_reg[gi] ^ rb_reg[gi] ^ carry[gi];
    assign carry[gi + 1] = (ra_reg[gi] & rb_reg[gi]) | (carry[gi] & (ra_reg[gi] ^ rb_reg[gi]));
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      ra_reg    <= '0;
      rb_reg    <= '0;
      rc_reg    <= 1'b0;
      rs_reg    <= '0;
      valid_reg <= 1'b0;
      pend_reg  <= 1'b0;
    end else if (load) begin
      ra_reg    <= a;
      rb_reg    <= b;
      rc_reg    <= c_in;
      valid_reg <= 1'b0;
      pend_reg  <= 1'b1;
    end else if (pend_reg) begin
      rs_reg    <= {carry[WIDTH], sum_bits};
      valid_reg <= 1'b1;
      pend_reg  <= 1'b0;
    end
  end

  logic refresh_wrap, scan_wrap;
  assign refresh_wrap = (refresh_reg == RCW'(REFRESH_DIV - 1));
  assign scan_wrap    = refresh_wrap && (digit_idx_reg == DW'(DIGITS - 1));

  // digit_idx_reg is the next digit to light; disp_idx_reg is the one being driven.
  always_ff @(posedge clk) begin
    if (clr) begin
      refresh_reg   <= '0;
      digit_idx_reg <= '0;
      disp_idx_reg  <= '0;
      live_reg      <= 1'b0;
    end else begin
      refresh_reg <= refresh_wrap ? '0 : refresh_reg + RCW'(1);
      if (refresh_wrap) begin
        digit_idx_reg <= (digit_idx_reg == DW'(DIGITS - 1)) ? '0 : digit_idx_reg + DW'(1);
        disp_idx_reg  <= digit_idx_reg;
        live_reg      <= 1'b1;
      end
    end
  end

  page_e mode_page;
  assign mode_page = page_e'(mode);

  always_ff @(posedge clk) begin
    if (clr) begin
      rotate_reg <= '0;
      page_reg   <= PAGE_A;
      auto_reg   <= 1'b0;
    end else begin
      auto_reg <= (mode_page == PAGE_AUTO);
      if (mode_page != PAGE_AUTO) begin
        rotate_reg <= '0;
        page_reg   <= mode_page;
      end else if (!auto_reg) begin
        rotate_reg <= '0;
        page_reg   <= PAGE_A;
      end else if (scan_wrap) begin
        if (rotate_reg == ROTW'(ROTATE_SCANS - 1)) begin
          rotate_reg <= '0;
          page_reg   <= next_page(page_reg);
        end else begin
          rotate_reg <= rotate_reg + ROTW'(1);
        end
      end
    end
  end

  // Page seen by the output stage this cycle, so mode changes land at the next edge.
  page_e cur_page;
  always_comb begin
    cur_page = mode_page;
    if (mode_page == PAGE_AUTO)
      cur_page = auto_reg ? page_reg : PAGE_A;
  end

  logic [PW-1:0] page_val;
  always_comb begin
    case (cur_page)
      PAGE_A:  page_val = PW'(ra_reg);
      PAGE_B:  page_val = PW'(rb_reg);
      default: page_val = PW'(rs_reg);
    endcase
  end

  logic [3:0]        nib_arr [DIGITS];
  logic [DIGITS-1:0] upper_zero;
  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_nibble
    assign nib_arr[gi]    = page_val[4*gi +: 4];
    assign upper_zero[gi] = (page_val[PW-1:4*gi] == '0);
  end

  logic [6:0] dec_seg;
  hex_to_svn_seg u_dec (
    .nibble (nib_arr[disp_idx_reg]),
    .seg    (dec_seg)
  );

  logic blank;
  assign blank = (BLANK_ZEROS != 0) && (disp_idx_reg != '0) && upper_zero[disp_idx_reg];

  always_ff @(posedge clk) begin
    if (clr || !live_reg) begin
      an_reg <= '1;
      ca_reg <= SEG_BLANK;
      dp_reg <= 1'b1;
    end else begin
      an_reg <= ~(DIGITS'(1) << disp_idx_reg);
      ca_reg <= blank ? SEG_BLANK : dec_seg;
      dp_reg <= (disp_idx_reg != DW'(cur_page));
    end
  end

  assign valid = valid_reg;
  assign an    = an_reg;
  assign ca    = ca_reg;
  assign dp    = dp_reg;

endmodule

// File: tb/tb_multi_digit_adder_display.sv
// Self-checking bench: two display instances (blanking on/off) compared every
// cycle against an arithmetic reference of capture, scan timing and paging.
module tb_multi_digit_adder_display;

  localparam int W  = 8;
  localparam int DG = 4;
  localparam int RD = 4;
  localparam int RS = 2;
  localparam int SCAN = RD * DG;

  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic [7:0] a = '0, b = '0;
  logic       c_in = 1'b0, load = 1'b0;
  logic [1:0] mode = 2'd0;

  logic       valid, valid_nb;
  logic [3:0] an, an_nb;
  logic [6:0] ca, ca_nb;
  logic       dp, dp_nb;

  multi_digit_adder_display #(.WIDTH(W), .DIGITS(DG), .REFRESH_DIV(RD),
                              .ROTATE_SCANS(RS), .BLANK_ZEROS(1)) dut (
    .clk(clk), .clr(clr), .a(a), .b(b), .c_in(c_in), .load(load), .mode(mode),
    .valid(valid), .an(an), .ca(ca), .dp(dp));

  multi_digit_adder_display #(.WIDTH(W), .DIGITS(DG), .REFRESH_DIV(RD),
                              .ROTATE_SCANS(RS), .BLANK_ZEROS(0)) dut_nb (
    .clk(clk), .clr(clr), .a(a), .b(b), .c_in(c_in), .load(load), .mode(mode),
    .valid(valid_nb), .an(an_nb), .ca(ca_nb), .dp(dp_nb));

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  int         t = 0;
  logic [7:0] m_ra = '0, m_rb = '0;
  logic       m_rc = 1'b0;
  logic [8:0] m_rs = '0;
  logic       m_valid = 1'b0, m_pend = 1'b0;
  bit         m_auto = 1'b0;
  int         entry_t = 0;
  logic [3:0] exp_an = 4'hF;
  logic [6:0] exp_ca = 7'h7F, exp_ca_nb = 7'h7F;
  logic       exp_dp = 1'b1;

  function automatic logic [6:0] seg_of(input int n);
    case (n)
      0: return 7'h40;   1: return 7'h79;   2: return 7'h24;   3: return 7'h30;
      4: return 7'h19;   5: return 7'h12;   6: return 7'h02;   7: return 7'h78;
      8: return 7'h00;   9: return 7'h10;  10: return 7'h08;  11: return 7'h03;
     12: return 7'h46;  13: return 7'h21;  14: return 7'h06;  default: return 7'h0E;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, t);
    end
  endtask

  // One clock edge: update the model with the inputs present at the edge,
  // then compare both instances half a cycle later.
  task automatic tick();
    int d, p, val, nib;
    @(posedge clk);
    if (clr) begin
      t = 0; m_ra = '0; m_rb = '0; m_rc = 1'b0; m_rs = '0;
      m_valid = 1'b0; m_pend = 1'b0; m_auto = 1'b0;
      exp_an = 4'hF; exp_ca = 7'h7F; exp_ca_nb = 7'h7F; exp_dp = 1'b1;
    end else begin
      t++;
      if (t - 1 < RD) begin
        exp_an = 4'hF; exp_ca = 7'h7F; exp_ca_nb = 7'h7F; exp_dp = 1'b1;
      end else begin
        d = ((t - 1) / RD - 1) % DG;
        if (mode != 2'd3)  p = int'(mode);
        else if (!m_auto)  p = 0;
        else               p = (((t - 1) / SCAN - entry_t / SCAN) / RS) % 3;
        val = (p == 0) ? int'(m_ra) : (p == 1) ? int'(m_rb) : int'(m_rs);
        nib = (val >> (4 * d)) & 15;
        exp_an    = ~(4'b0001 << d);
        exp_ca_nb = seg_of(nib);
        exp_ca    = (d > 0 && (val >> (4 * d)) == 0) ? 7'h7F : seg_of(nib);
        exp_dp    = (d != p);
      end
      if (mode == 2'd3 && !m_auto) entry_t = t;
      m_auto = (mode == 2'd3);
      if (load) begin
        m_ra = a; m_rb = b; m_rc = c_in; m_valid = 1'b0; m_pend = 1'b1;
      end else if (m_pend) begin
        m_rs = 9'(int'(m_ra) + int'(m_rb) + int'(m_rc));
        m_valid = 1'b1; m_pend = 1'b0;
      end
    end
    @(negedge clk);
    chk("valid", 32'(valid), 32'(m_valid));
    chk("an", 32'(an), 32'(exp_an));
    chk("ca", 32'(ca), 32'(exp_ca));
    chk("dp", 32'(dp), 32'(exp_dp));
    chk("valid_nb", 32'(valid_nb), 32'(m_valid));
    chk("an_nb", 32'(an_nb), 32'(exp_an));
    chk("ca_nb", 32'(ca_nb), 32'(exp_ca_nb));
    chk("dp_nb", 32'(dp_nb), 32'(exp_dp));
    $display("cycle %0d clr=%0b load=%0b mode=%0d valid=%0b an=%h ca=%h dp=%0b",
             t, clr, load, mode, valid, an, ca, dp);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_load(input logic [7:0] va, input logic [7:0] vb, input logic vc);
    a = va; b = vb; c_in = vc; load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  initial begin
    int cnt;
    // Reset, then run mid-scan and reset again for three cycles
    run(2);
    clr = 1'b0;
    run(7);
    clr = 1'b1;
    run(3);
    chk("reset_an", 32'(an), 32'h0000000F);
    chk("reset_ca", 32'(ca), 32'h0000007F);
    clr = 1'b0;
    cnt = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (an != 4'hF) begin cnt = i; break; end
    end
    chk("first_anode_latency", 32'(cnt), 32'(RD + 1));
    chk("first_anode_value", 32'(an), 32'h0000000E);

    // FF + 01 + 1 on the sum page
    mode = 2'd2;
    do_load(8'hFF, 8'h01, 1'b1);
    chk("valid_low_after_load", 32'(valid), 32'h0);
    tick();
    chk("valid_high_next", 32'(valid), 32'h1);
    run(40);

    // 3C on page A: upper digits blanked only on the blanking instance
    mode = 2'd0;
    do_load(8'h3C, 8'h00, 1'b0);
    run(24);

    // Back-to-back loads
    do_load(8'h12, 8'h34, 1'b0);
    do_load(8'h05, 8'h06, 1'b0);
    chk("b2b_valid_low", 32'(valid), 32'h0);
    mode = 2'd2;
    tick();
    chk("b2b_valid_high", 32'(valid), 32'h1);
    run(24);

    // Auto-rotate, leave to page B, re-enter
    mode = 2'd3;
    run(110);
    mode = 2'd1;
    run(10);
    mode = 2'd3;
    run(70);

    // Reset coincident with a load
    mode = 2'd2;
    a = 8'hAA; b = 8'h55; c_in = 1'b1; load = 1'b1; clr = 1'b1;
    tick();
    clr = 1'b0; load = 1'b0;
    run(30);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        a = 8'($urandom); b = 8'($urandom); c_in = 1'($urandom); load = 1'b1;
      end else begin
        load = 1'b0;
      end
      if ($urandom_range(0, 31) == 0) mode = 2'($urandom_range(0, 3));
      clr = ($urandom_range(0, 199) == 0);
      tick();
    end
    clr = 1'b0; load = 1'b0;
    run(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/multi_digit_adder_display.md
Name: multi_digit_adder_display

Overview:
- Parametrised successor to the 4-bit adder display.
- Captures two WIDTH-bit operands and a carry-in on a load strobe, then registers the (WIDTH+1)-bit sum.
- Drives a time-multiplexed, active-low DIGITS-digit seven-segment display.
- A page select shows operand A, operand B or the sum; an auto-rotate mode cycles through all three. Leading-zero blanking is optional.

Parameters:
- WIDTH, 8: operand width in bits; multiple of 4, range 4..16.
- DIGITS, 4: number of display digits; range 3..8.
- REFRESH_DIV, 100000: clk cycles each digit is held before the scan advances; must be ≥ 2.
- ROTATE_SCANS, 256: full scan cycles per page in auto-rotate mode; must be ≥ 1.
- BLANK_ZEROS, 1: 1 = blank leading zero digits; digit 0 is never blanked.

Ports:
- clk  in  1  system clock.
- clr  in  1  synchronous, active-high reset.
- a  in  WIDTH  addend A.
- b  in  WIDTH  addend B.
- c_in  in  1  carry in.
- load  in  1  operand capture strobe.
- mode  in  2  page select: 0 = A, 1 = B, 2 = sum, 3 = auto-rotate.
- valid  out  1  sum register holds the result for the captured operands.
- an  out  DIGITS  anode enables, active-low, one-hot-low.
- ca  out  7  cathodes, active-low, bit 0 = segment a ... bit 6 = segment g.
- dp  out  1  decimal point, active-low.

Behaviour:
- Reset (clr=1 at a clk edge):
  - operand registers ra, rb, rc = 0; sum register rs = 0; valid = 0.
  - refresh counter, digit index, rotate counter and page = 0.
  - an = all 1s, ca = 7'h7F, dp = 1 (display dark).
  - Reset applied mid-scan or mid-load takes priority over every other event.
- Capture:
  - load=1 at edge k latches a, b, c_in into ra, rb, rc.
  - rs = ra + rb + rc (WIDTH+1 bits, ripple carry) is registered at edge k+1; valid rises at k+1.
  - valid falls at edge k and stays low until k+1, so it reads 0 for exactly one cycle after each load.
  - Back-to-back loads: each load recaptures the operands; valid stays low until the cycle after the last load.
  - Operand inputs are ignored while load=0.
- Scan:
  - The refresh counter counts 0..REFRESH_DIV-1 and wraps.
  - On wrap, the digit index advances modulo DIGITS; index DIGITS-1 returns to 0.
  - an, ca and dp are registered and update together one cycle after the index changes. No glitch in which two anodes are low at once.
- Page value (zero-extended to 4*DIGITS bits):
  - A = ra; B = rb; sum = rs. Bit WIDTH of rs (the carry out) forms the nibble at index WIDTH/4.
  - Digit i shows nibble i through the hex decoder (0-F, standard Basys-style patterns).
  - Nibbles above the page width display 0, or are blanked when BLANK_ZEROS=1.
- Blanking (BLANK_ZEROS=1):
  - Digit i > 0 is blanked (ca = 7'h7F) when nibble i and every higher nibble are zero.
  - The anode is still driven.
- Page indicator:
  - dp = 0 only on digit index == page number (A: digit 0, B: digit 1, sum: digit 2).
  - dp = 1 on all other digits.
- Auto-rotate (mode=3):
  - Each index wrap from DIGITS-1 to 0 increments the rotate counter.
  - At ROTATE_SCANS the counter clears and page advances A → B → sum → A.
  - Leaving mode 3 clears the rotate counter. Re-entering mode 3 restarts at page A.
  - In modes 0-2, page = mode, applied at the next clk edge.
- Mode change mid-digit takes effect on the registered outputs at the next edge; the scan counter is not disturbed.

Decomposition:
- Shared package (adder_display_pkg):
  - page encodings PAGE_A, PAGE_B, PAGE_SUM, PAGE_AUTO.
  - the 16-entry active-low segment constant table.
  - blank pattern SEG_BLANK = 7'h7F.
- One sub-module: hex_to_svn_seg, a combinational 4-bit nibble to 7-bit active-low segment decoder, instantiated once on the selected nibble.

Test Plan:
All scenarios use WIDTH=8, DIGITS=4, REFRESH_DIV=4, ROTATE_SCANS=2.
- Reset: hold clr 3 cycles mid-scan → an=4'hF, ca=7'h7F, dp=1, valid=0. First anode low (an=4'b1110) appears REFRESH_DIV+1 cycles after release.
- Load a=8'hFF, b=8'h01, c_in=1, mode=2 → valid=0 for one cycle, then 1; rs=9'h101. Scan shows digit0 "1", digit1 "0", digit2 "1", digit3 blanked; dp low on digit 2 only.
- Load a=8'h3C, b=8'h00, c_in=0, mode=0, BLANK_ZEROS=1 → digits 0/1 show "C"/"3", digits 2/3 ca=7'h7F. Rerun with BLANK_ZEROS=0 → digits 2/3 show "0".
- Back-to-back loads (8'h12+8'h34, then 8'h05+8'h06 next cycle) → valid stays 0 until the cycle after the second load; sum page shows 0B.
- mode=3 → pages A, B, sum, A each last 2 full scans (32 cycles). Switching to mode=1 and back to 3 restarts at page A.
- Assert clr during a load cycle → operand and sum registers read 0 and valid=0 afterwards; the load is lost.
